// File: rtl/inst_fetch_seq.sv
// Instruction store plus program sequencer feeding the decoder.
// Steps a PC from 0 to a latched end address with one hardware loop and honours a downstream stall.
module inst_fetch_seq #(
    parameter int  InstWidth    = 32,
    parameter int  NumInst      = 64,
    parameter int  LoopCntWidth = 8,
    localparam int AddrWidth    = $clog2(NumInst)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    inst_wr_en_i,
    input  logic [AddrWidth-1:0]    inst_wr_addr_i,
    input  logic [InstWidth-1:0]    inst_wr_data_i,
    input  logic                    start_i,
    input  logic                    stall_i,
    input  logic [AddrWidth-1:0]    prog_end_addr_i,
    input  logic                    loop_en_i,
    input  logic [AddrWidth-1:0]    loop_start_addr_i,
    input  logic [AddrWidth-1:0]    loop_end_addr_i,
    input  logic [LoopCntWidth-1:0] loop_count_i,
    output logic [InstWidth-1:0]    inst_code_o,
    output logic                    inst_valid_o,
    output logic [AddrWidth-1:0]    pc_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [AddrWidth-1:0]    r_pc;
    logic [AddrWidth-1:0]    r_prog_end;
    logic [AddrWidth-1:0]    r_loop_start;
    logic [AddrWidth-1:0]    r_loop_end;
    logic                    r_loop_en;
    logic [LoopCntWidth-1:0] r_loop_cnt;
    logic [LoopCntWidth-1:0] r_loop_iter;
    logic                    r_busy;
    logic                    r_done;
    logic [InstWidth-1:0]    r_mem [NumInst];

    logic                    w_loop_active;
    logic                    w_loop_repeat;
    logic [AddrWidth-1:0]    w_pc_inc;
    logic [LoopCntWidth:0]   w_iter_next;

    assign w_loop_active = r_loop_en && (r_loop_start <= r_loop_end);
    // One extra bit so iter+1 cannot overflow before the compare.
    assign w_iter_next   = {1'b0, r_loop_iter} + (LoopCntWidth + 1)'(1);
    assign w_loop_repeat = w_loop_active && (r_pc == r_loop_end)
                           && (w_iter_next < {1'b0, r_loop_cnt});
    assign w_pc_inc      = (r_pc == AddrWidth'(NumInst - 1)) ? '0 : r_pc + AddrWidth'(1);

    always_ff @(posedge clk_i) begin
        if (r_state == S_IDLE && inst_wr_en_i) begin
            r_mem[inst_wr_addr_i] <= inst_wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_loop_iter  <= '0;
            r_prog_end   <= '0;
            r_loop_en    <= 1'b0;
            r_loop_start <= '0;
            r_loop_end   <= '0;
            r_loop_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_prog_end   <= prog_end_addr_i;
                        r_loop_en    <= loop_en_i;
                        r_loop_start <= loop_start_addr_i;
                        r_loop_end   <= loop_end_addr_i;
                        r_loop_cnt   <= loop_count_i;
                        r_pc         <= '0;
                        r_loop_iter  <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall_i) begin
                        // Loop repeat is checked first so a body ending on prog_end still repeats.
                        if (w_loop_repeat) begin
                            r_pc        <= r_loop_start;
                            r_loop_iter <= w_iter_next[LoopCntWidth-1:0];
                        end else if (r_pc == r_prog_end) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (r_pc == r_loop_end) begin
                            r_loop_iter <= '0;
                            r_pc        <= w_pc_inc;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_code_o  = r_mem[r_pc];
    assign inst_valid_o = (r_state == S_RUN) && !stall_i;
    assign pc_o         = r_pc;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq: directed scenarios plus randomized programs and stalls
// checked against an expected issue-order list built from the loop/program addresses.
module tb_inst_fetch_seq;
    localparam int IW = 32;
    localparam int NI = 64;
    localparam int LW = 8;
    localparam int AW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          inst_wr_en_i = 1'b0;
    logic [AW-1:0] inst_wr_addr_i = '0;
    logic [IW-1:0] inst_wr_data_i = '0;
    logic          start_i = 1'b0;
    logic          stall_i = 1'b0;
    logic [AW-1:0] prog_end_addr_i = '0;
    logic          loop_en_i = 1'b0;
    logic [AW-1:0] loop_start_addr_i = '0;
    logic [AW-1:0] loop_end_addr_i = '0;
    logic [LW-1:0] loop_count_i = '0;
    logic [IW-1:0] inst_code_o;
    logic          inst_valid_o;
    logic [AW-1:0] pc_o;
    logic          busy_o;
    logic          done_o;

    inst_fetch_seq dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_wr_en_i(inst_wr_en_i), .inst_wr_addr_i(inst_wr_addr_i), .inst_wr_data_i(inst_wr_data_i),
        .start_i(start_i), .stall_i(stall_i), .prog_end_addr_i(prog_end_addr_i),
        .loop_en_i(loop_en_i), .loop_start_addr_i(loop_start_addr_i), .loop_end_addr_i(loop_end_addr_i),
        .loop_count_i(loop_count_i), .inst_code_o(inst_code_o), .inst_valid_o(inst_valid_o),
        .pc_o(pc_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [IW-1:0] mem_m [NI];
    int q_exp [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected issue order: straight line 0..pe, with the loop body replayed
    // (count-1) extra times right after its first pass when it lies within the program.
    task automatic build_exp(input int pe, input bit len, input int ls, input int le, input int cnt);
        int reps;
        q_exp.delete();
        if (len && ls <= le && le <= pe) begin
            reps = (cnt <= 1) ? 0 : cnt - 1;
            for (int a = 0; a <= le; a++) q_exp.push_back(a);
            for (int r = 0; r < reps; r++)
                for (int a = ls; a <= le; a++) q_exp.push_back(a);
            for (int a = le + 1; a <= pe; a++) q_exp.push_back(a);
        end else begin
            for (int a = 0; a <= pe; a++) q_exp.push_back(a);
        end
    endtask

    task automatic load(input int addr, input logic [IW-1:0] data);
        @(negedge clk_i);
        inst_wr_en_i   = 1'b1;
        inst_wr_addr_i = AW'(addr);
        inst_wr_data_i = data;
        mem_m[addr]    = data;
        @(negedge clk_i);
        inst_wr_en_i   = 1'b0;
    endtask

    // stall_mode: 0 none, 1 random, 2 three stall cycles while pc==2
    task automatic run(input string tag, input int pe, input bit len, input int ls, input int le,
                       input int cnt, input int stall_mode, input bit wr_mid,
                       input bit ws, input int wa, input logic [IW-1:0] wd);
        int cyc = 0, stalls = 0, issued = 0, st2 = 0, ep;
        bit done_seen = 0, s;
        @(negedge clk_i);
        prog_end_addr_i   = AW'(pe);
        loop_en_i         = len;
        loop_start_addr_i = AW'(ls);
        loop_end_addr_i   = AW'(le);
        loop_count_i      = LW'(cnt);
        start_i           = 1'b1;
        if (ws) begin
            inst_wr_en_i   = 1'b1;
            inst_wr_addr_i = AW'(wa);
            inst_wr_data_i = wd;
            mem_m[wa]      = wd;
        end
        build_exp(pe, len, ls, le, cnt);
        @(negedge clk_i);
        while (cyc < 500 && !done_seen) begin
            cyc++;
            s = 0;
            if (stall_mode == 1) s = ($urandom_range(0, 3) == 0);
            if (stall_mode == 2 && q_exp.size() > 0 && q_exp[0] == 2 && st2 < 3) begin
                s = 1;
                st2++;
            end
            stall_i = s;
            if (wr_mid && cyc == 2) begin
                inst_wr_en_i   = 1'b1;
                inst_wr_addr_i = AW'(1);
                inst_wr_data_i = 32'hDEAD_BEEF;
                start_i        = 1'b1;
            end else begin
                inst_wr_en_i = 1'b0;
                start_i      = 1'b0;
            end
            prog_end_addr_i   = AW'($urandom);
            loop_en_i         = 1'($urandom);
            loop_start_addr_i = AW'($urandom);
            loop_end_addr_i   = AW'($urandom);
            loop_count_i      = LW'($urandom);
            #1;
            if (done_o) begin
                done_seen = 1;
                chk({tag, " leftover"}, q_exp.size(), 0);
                chk({tag, " done_cycle"}, cyc, issued + stalls + 1);
                chk({tag, " done_valid"}, inst_valid_o, 0);
                chk({tag, " done_busy"}, busy_o, 0);
            end else if (q_exp.size() == 0) begin
                chk({tag, " late_done"}, done_o, 1);
            end else begin
                ep = q_exp[0];
                chk({tag, " pc"}, pc_o, ep);
                chk({tag, " code"}, inst_code_o, mem_m[ep]);
                chk({tag, " valid"}, inst_valid_o, !s);
                chk({tag, " busy"}, busy_o, 1);
                if (s) stalls++;
                else begin
                    void'(q_exp.pop_front());
                    issued++;
                end
            end
            if (!done_seen) @(negedge clk_i);
        end
        stall_i      = 1'b0;
        start_i      = 1'b0;
        inst_wr_en_i = 1'b0;
        if (!done_seen) chk({tag, " timeout"}, done_o, 1);
        @(negedge clk_i);
        #1;
        chk({tag, " idle_busy"}, busy_o, 0);
        chk({tag, " idle_done"}, done_o, 0);
        chk({tag, " idle_valid"}, inst_valid_o, 0);
    endtask

    initial begin
        int pe, ls, le, cnt, g;
        bit len;
        #1;
        chk("rst pc", pc_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst valid", inst_valid_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int a = 0; a < 3; a++) load(a, 32'hA0 + a);
        run("basic", 3, 0, 0, 0, 0, 0, 0, 1, 3, 32'hA3);
        for (int a = 0; a < 8; a++) load(a, 32'h100 + a);
        run("loop12", 5, 1, 1, 2, 3, 0, 0, 0, 0, '0);
        for (int a = 0; a < 4; a++) load(a, 32'hA0 + a);
        run("stall", 3, 0, 0, 0, 0, 2, 0, 0, 0, '0);
        run("tail_loop", 3, 1, 2, 3, 2, 0, 0, 0, 0, '0);
        run("cnt0", 3, 1, 2, 3, 0, 0, 0, 0, 0, '0);
        run("wr_in_run", 3, 0, 0, 0, 0, 0, 1, 0, 0, '0);
        run("readback", 3, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        @(negedge clk_i);
        start_i = 1'b1; prog_end_addr_i = 3; loop_en_i = 0;
        @(negedge clk_i);
        start_i = 1'b0;
        g = 0;
        while (!(inst_valid_o && pc_o == 2) && g < 20) begin
            @(negedge clk_i);
            g++;
        end
        chk("mid_rst reach_pc2", pc_o, 2);
        rst_i = 1'b1;
        #1;
        chk("mid_rst valid", inst_valid_o, 0);
        chk("mid_rst busy", busy_o, 0);
        chk("mid_rst pc", pc_o, 0);
        @(negedge clk_i);
        chk("mid_rst done", done_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst done", done_o, 0);
        run("after_rst", 3, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        for (int r = 0; r < 14; r++) begin
            for (int a = 0; a < 16; a++) load(a, $urandom);
            pe  = $urandom_range(0, 15);
            len = 1'($urandom);
            ls  = $urandom_range(0, 15);
            le  = $urandom_range(0, 15);
            cnt = $urandom_range(0, 4);
            run($sformatf("rand%0d", r), pe, len, ls, le, cnt, 1, 0, 0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch_seq.md
Name: inst_fetch_seq

Overview:
- Instruction memory plus program sequencer that sits directly upstream of the instruction decoder.
- Holds a small host-programmed instruction store and steps a program counter (PC) through it.
- Supports one hardware loop (start/end address, iteration count).
- Presents one instruction per cycle with a valid flag that drives the decoder's enable input, and honours a downstream stall.

Parameters:
- InstWidth, 32, instruction word width in bits.
- NumInst, 64, instruction memory depth in words.
- LoopCntWidth, 8, width of the loop iteration counter.
- AddrWidth, $clog2(NumInst), PC and address width (derived; do not override).

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset.
- inst_wr_en_i, input, 1, host write strobe into instruction memory.
- inst_wr_addr_i, input, AddrWidth, host write address.
- inst_wr_data_i, input, InstWidth, host write data.
- start_i, input, 1, start-program pulse.
- stall_i, input, 1, downstream not ready; hold the current instruction.
- prog_end_addr_i, input, AddrWidth, address of the last program instruction.
- loop_en_i, input, 1, enable the hardware loop.
- loop_start_addr_i, input, AddrWidth, first instruction of the loop body.
- loop_end_addr_i, input, AddrWidth, last instruction of the loop body.
- loop_count_i, input, LoopCntWidth, total number of loop-body executions.
- inst_code_o, output, InstWidth, current instruction; feeds the decoder's inst_code_i.
- inst_valid_o, output, 1, instruction issued this cycle; feeds the decoder's enable_i.
- pc_o, output, AddrWidth, current PC.
- busy_o, output, 1, sequencer is in RUN.
- done_o, output, 1, one-cycle pulse after the last instruction issues.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, pc=0, loop_iter=0, all latched configuration=0, busy_o=0, done_o=0, inst_valid_o=0.
- Instruction memory contents are not reset.

Memory:
- NumInst x InstWidth register array.
- Written on a clk_i edge when inst_wr_en_i=1 and state is IDLE.
- Writes while in RUN are ignored.
- Read is combinational: inst_code_o = mem[pc] in every state.

FSM states: IDLE, RUN, DONE.
- IDLE: on start_i=1:
  - latch prog_end_addr_i, loop_en_i, loop_start_addr_i, loop_end_addr_i, loop_count_i;
  - set pc=0 and loop_iter=0;
  - go to RUN.
  - The first instruction issues the following cycle.
  - If inst_wr_en_i and start_i are high in the same cycle, the write completes and start is still taken.
- RUN:
  - inst_valid_o = ~stall_i (combinational). busy_o=1.
  - While stall_i=1: pc, loop_iter and state hold; inst_code_o stays stable.
  - When stall_i=0, the instruction at pc issues and the next pc is chosen in this priority order:
    1. Loop active (latched loop_en=1 and loop_start<=loop_end), pc==loop_end, and loop_iter+1 < loop_count: pc<=loop_start, loop_iter<=loop_iter+1.
    2. pc==prog_end: go to DONE; pc holds.
    3. pc==loop_end (loop exhausted): loop_iter<=0, pc<=pc+1.
    4. Otherwise: pc<=pc+1.
  - loop_count of 0 or 1 means the body executes once (no repeat).
  - Rule 1 beats rule 2 when loop_end==prog_end, so a trailing loop body still repeats.
  - pc increment wraps modulo NumInst. If prog_end is never reached the sequencer runs until reset; this is legal.
  - start_i is ignored in RUN.
- DONE: done_o=1 for exactly one cycle, inst_valid_o=0, busy_o=0. Next cycle go to IDLE.
  - start_i is ignored in DONE.
- Latency: from the start_i edge, the first inst_valid_o is high in the next cycle (assuming no stall).
- Configuration inputs may change during RUN without effect; only the values latched at start are used.
- Reset asserted mid-run: return to IDLE immediately and drop inst_valid_o asynchronously. No partial done_o.

Test Plan:
- Load mem[0..3]=0xA0..0xA3, prog_end=3, loop_en=0, pulse start -> inst_valid_o high for 4 consecutive cycles with inst_code_o 0xA0,0xA1,0xA2,0xA3; done_o pulses in the 5th cycle; busy_o low afterwards.
- prog_end=5, loop_en=1, loop 1..2, count=3 -> issued PC sequence 0,1,2,1,2,1,2,3,4,5 (10 valid cycles), then done_o.
- Same as the first scenario, with stall_i high for 3 cycles while pc=2 -> inst_valid_o low for those cycles, inst_code_o held at 0xA2, sequence otherwise unchanged, done_o delayed by 3 cycles.
- Loop 2..3 with loop_end=prog_end=3, count=2 -> sequence 0,1,2,3,2,3, then done_o; loop_count=0 instead -> sequence 0,1,2,3.
- During RUN, write mem[1] and pulse start -> both ignored; the program completes normally; a later readback run shows the old mem[1].
- Assert rst_i mid-run at pc=2 -> inst_valid_o, busy_o and pc go to 0 immediately, no done_o; a new start runs from pc=0.
